mcmem_master: RTL and testbench

- Memory-side initiator for the multicycle CPU's 32-bit synchronous data/instruction RAM.
- The RAM registers address, write enable and data on input, and registers its data output.
- This block accepts one load/store request at a time from the CPU control path, sequences the RAM access to meet the RAM's two-edge read latency, and performs byte/halfword extraction on loads and read-modify-write on sub-word stores.
- It returns one response pulse per request.

---
 rtl/mcmem_pkg.sv | 32 +++
 rtl/mcmem_lane.sv | 52 +++++
 rtl/mcmem_master.sv | 167 ++++++++++++++++
 tb/tb_mcmem_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcmem_pkg.sv
// Shared encodings and helpers for the multicycle CPU memory initiator.
package mcmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] RSP    = 3'd4;

  localparam int unsigned RD_LAT_DEFAULT = 2;

  // Size code 3 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SZ_WORD : size;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mcmem_lane.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module mcmem_lane
  import mcmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_BYTE: rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: rdata_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        unique case (addr_lo_i)
          2'd0: merged_o[7:0]   = wdata_i[7:0];
          2'd1: merged_o[15:8]  = wdata_i[7:0];
          2'd2: merged_o[23:16] = wdata_i[7:0];
          2'd3: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mcmem_master.sv
// Single-outstanding load/store initiator for a synchronous RAM with registered in/out,
// including sub-word extraction and read-modify-write for sub-word stores.
module mcmem_master
  import mcmem_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEFAULT,
  parameter int unsigned AW     = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_datain,
  output logic          mem_we,
  input  logic [31:0]   mem_dataout
);

  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_datain_q, mem_datain_d;
  logic            mem_we_q, mem_we_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [1:0]      req_size_n;
  logic [31:0]     lane_rdata;
  logic [31:0]     lane_merged;

  assign req_size_n = norm_size(req_size);

  mcmem_lane u_lane (
    .word_i    (mem_dataout),
    .wdata_i   (wdata_q),
    .addr_lo_i (addr_lo_q),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .rdata_o   (lane_rdata),
    .merged_o  (lane_merged)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    mem_we_d     = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          size_d    = req_size_n;
          signed_d  = req_signed;
          wdata_d   = req_wdata;
          cnt_d     = '0;
          if (misaligned(req_size_n, req_addr[1:0])) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            mem_addr_d = {req_addr[AW-1:2], 2'b00};
            if (req_we && req_size_n == SZ_WORD) begin
              state_d      = WR;
              mem_datain_d = req_wdata;
              mem_we_d     = 1'b1;
            end else if (req_we) begin
              state_d = RMW_RD;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD, RMW_RD: begin
        // mem_dataout is valid once RD_LAT edges have passed since the address was presented.
        if (cnt_q == CntW'(RD_LAT)) begin
          if (state_q == RD) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = lane_rdata;
          end else begin
            state_d      = WR;
            mem_datain_d = lane_merged;
            mem_we_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_lo_q    <= '0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      mem_we_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      mem_we_q     <= mem_we_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_datain = mem_datain_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_mcmem_master.sv
// Directed bench for mcmem_master against a registered-in/registered-out RAM model.
module tb_mcmem_master;
  import mcmem_pkg::*;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          clrn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_datain;
  logic          mem_we;
  logic [31:0]   mem_dataout;

  always #5 clk = ~clk;

  mcmem_master #(
    .RD_LAT (2),
    .AW     (AW)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_we      (mem_we),
    .mem_dataout (mem_dataout)
  );

  // RAM model: input register stage, then registered read data; not reset.
  logic [31:0] ram [0:63];
  logic [5:0]  ram_a_q;
  logic        ram_we_q;
  logic [31:0] ram_d_q;

  always @(posedge clk) begin
    ram_a_q  <= mem_addr[7:2];
    ram_we_q <= mem_we;
    ram_d_q  <= mem_datain;
    if (ram_we_q) ram[ram_a_q] <= ram_d_q;
    mem_dataout <= ram[ram_a_q];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   rsp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response pulse pops one expected entry.
  always @(negedge clk) begin
    if (clrn === 1'b1 && rsp_valid === 1'b1) begin
      rsp_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected got=%0d exp=0 stray responses", 1);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_we);
    int   lat;
    int   wes;
    rsp_t e;
    @(negedge clk);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
    lat = 0;
    wes = 0;
    for (int n = 1; n <= 20; n++) begin
      if (mem_we === 1'b1) wes++;
      if (rsp_valid === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_wepulses"}, wes, exp_we);
    @(negedge clk);
    check({tag, "_rsp_drop"}, {30'b0, rsp_valid, rsp_err}, 32'd0);
    check({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  logic [31:0] bb_addr  [3];
  logic [31:0] bb_wdata [3];
  logic        bb_we    [3];
  logic [1:0]  bb_size  [3];
  logic [31:0] bb_exp   [3];
  int          rsp_base;
  rsp_t        bb_e;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    clrn       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = SZ_WORD;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_outs", {29'b0, rsp_valid, rsp_err, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    clrn = 1'b1;

    do_req("sw",  1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1);
    do_req("lw",  1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4, 0);
    do_req("lb",  1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 4, 0);
    do_req("lbu", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0,        32'h000000DE, 1'b0, 4, 0);
    do_req("lh",  1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 4, 0);
    do_req("lhu", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 4, 0);
    do_req("sh",  1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234,     32'h0,        1'b0, 5, 1);
    do_req("lw_sh", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,      32'h1234BEEF, 1'b0, 4, 0);
    do_req("sb",  1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h77,       32'h0,        1'b0, 5, 1);
    do_req("lw_sb", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,      32'h1234BE77, 1'b0, 4, 0);
    do_req("lw_mis", 1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0,     32'h0,        1'b1, 1, 0);
    do_req("sh_mis", 1'b1, SZ_HALF, 1'b0, 32'h13, 32'hFFFF,  32'h0,        1'b1, 1, 0);
    do_req("size3", 1'b0, 2'd3,   1'b0, 32'h10, 32'h0,       32'h1234BE77, 1'b0, 4, 0);

    // Reset during the read phase of a sub-word store.
    @(negedge clk);
    req_we     = 1'b1;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'h55;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_busy", {31'b0, req_ready}, 32'd0);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_outs", {29'b0, rsp_valid, rsp_err, mem_we}, 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    check("abort_datain", mem_datain, 32'd0);
    check("abort_rdata", rsp_rdata, 32'd0);
    rsp_base = rsp_cnt;
    repeat (8) @(negedge clk);
    check("abort_norsp", rsp_cnt - rsp_base, 0);
    do_req("lw_abort", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1234BE77, 1'b0, 4, 0);

    // Back-to-back with req_valid held high.
    bb_addr[0] = 32'h20; bb_wdata[0] = 32'hCAFEF00D; bb_we[0] = 1'b1; bb_size[0] = SZ_WORD;
    bb_exp[0]  = 32'h0;
    bb_addr[1] = 32'h20; bb_wdata[1] = 32'h0;        bb_we[1] = 1'b0; bb_size[1] = SZ_WORD;
    bb_exp[1]  = 32'hCAFEF00D;
    bb_addr[2] = 32'h21; bb_wdata[2] = 32'h0;        bb_we[2] = 1'b0; bb_size[2] = SZ_BYTE;
    bb_exp[2]  = 32'h000000F0;
    rsp_base = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      req_we     = bb_we[i];
      req_size   = bb_size[i];
      req_signed = 1'b0;
      req_addr   = bb_addr[i];
      req_wdata  = bb_wdata[i];
      req_valid  = 1'b1;
      bb_e.rdata = bb_exp[i];
      bb_e.err   = 1'b0;
      exp_q.push_back(bb_e);
      for (int w = 0; w < 20 && req_ready !== 1'b1; w++) @(negedge clk);
      check("bb_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      check("bb_taken", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("bb_rsp_count", rsp_cnt - rsp_base, 3);
    check("bb_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
